// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller.
//
// Holds the per-stage tag type carried down the result-holding stages,
// the default parameter values used by pipe_hazard_ctrl, and the
// forwarding-select code that means "read the register file".
package pipe_pkg;

    localparam int DEF_STAGES     = 3;
    localparam int DEF_REG_AW     = 5;
    localparam int DEF_LOAD_STAGE = 2;
    localparam int DEF_CNT_W      = 16;

    // Widest register number a tag can carry. Narrower REG_AW values
    // are zero-extended into this field, so comparisons stay exact.
    localparam int TAG_RN_W = 8;

    // Forwarding select value meaning "no in-flight producer".
    localparam int FWD_RF = 0;

    typedef struct packed {
        logic                valid;
        logic [TAG_RN_W-1:0] rn;
        logic                wreg;
        logic                m2reg;
    } stage_tag_t;

    localparam stage_tag_t TAG_EMPTY = '0;

endpackage

// File: rtl/pipe_tag_reg.sv
// One stage tag register of the hazard controller.
//
// Ports:
//   i_clk     clock, rising edge
//   i_rst     asynchronous active-high reset, clears the tag
//   i_hold    keep the current tag (highest priority after reset)
//   i_bubble  load an empty tag (valid=0)
//   i_load    load i_tag
//   i_tag     tag arriving from the previous stage / decode
//   o_tag     current tag
module pipe_tag_reg
    import pipe_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_hold,
    input  logic       i_bubble,
    input  logic       i_load,
    input  stage_tag_t i_tag,
    output stage_tag_t o_tag
);

    stage_tag_t r_tag;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_tag <= TAG_EMPTY;
        end else if (i_hold) begin
            r_tag <= r_tag;
        end else if (i_bubble) begin
            r_tag <= TAG_EMPTY;
        end else if (i_load) begin
            r_tag <= i_tag;
        end
    end

    assign o_tag = r_tag;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: tracks the destination tags of the
// instructions in the STAGES result-holding stages after decode,
// selects forwarding sources for the two decode operands, detects
// load-use hazards, and generates stall / flush / freeze controls.
//
// Ports:
//   i_clk, i_rst               clock, asynchronous active-high reset
//   i_id_valid                 decode holds a real instruction
//   i_id_rs, i_id_rt           source register numbers
//   i_id_use_rs, i_id_use_rt   source is actually read
//   i_id_rn                    destination register
//   i_id_wreg, i_id_m2reg      writes a register / result from memory
//   i_branch_taken             decode redirects the fetch stream
//   i_mc_busy                  multi-cycle unit freezes the whole pipe
//   o_wpcir                    PC and IF/ID write enable
//   o_id_bubble                ID/EXE loads a bubble
//   o_if_flush                 IF/ID loads a bubble
//   o_fwd_a, o_fwd_b           0 = register file, k = result of stage k
//   o_stage_valid              valid bit of each tracked stage (bit 0 = stage 1)
//   o_stall_cnt, o_flush_cnt   saturating load-use stall / flush counters
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int STAGES     = DEF_STAGES,
    parameter int REG_AW     = DEF_REG_AW,
    parameter int LOAD_STAGE = DEF_LOAD_STAGE,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_id_valid,
    input  logic [REG_AW-1:0]            i_id_rs,
    input  logic [REG_AW-1:0]            i_id_rt,
    input  logic                         i_id_use_rs,
    input  logic                         i_id_use_rt,
    input  logic [REG_AW-1:0]            i_id_rn,
    input  logic                         i_id_wreg,
    input  logic                         i_id_m2reg,
    input  logic                         i_branch_taken,
    input  logic                         i_mc_busy,
    output logic                         o_wpcir,
    output logic                         o_id_bubble,
    output logic                         o_if_flush,
    output logic [$clog2(STAGES+1)-1:0]  o_fwd_a,
    output logic [$clog2(STAGES+1)-1:0]  o_fwd_b,
    output logic [STAGES-1:0]            o_stage_valid,
    output logic [CNT_W-1:0]             o_stall_cnt,
    output logic [CNT_W-1:0]             o_flush_cnt
);

    localparam int FWD_W = $clog2(STAGES + 1);

    // Index 0 holds stage 1 (EXE), index STAGES-1 the top stage.
    stage_tag_t        w_tag_q [STAGES];
    stage_tag_t        w_tag_d [STAGES];
    stage_tag_t        w_dec_tag;

    logic [TAG_RN_W-1:0] w_rs_ext;
    logic [TAG_RN_W-1:0] w_rt_ext;
    logic [STAGES-1:0]   w_hit_a;
    logic [STAGES-1:0]   w_hit_b;
    logic [STAGES-1:0]   w_bubble;
    logic [FWD_W-1:0]    w_fwd_a;
    logic [FWD_W-1:0]    w_fwd_b;
    logic                w_lu_a;
    logic                w_lu_b;
    logic                w_load_use;
    logic                w_stall;
    logic                w_flush;

    logic [CNT_W-1:0]    r_stall_cnt;
    logic [CNT_W-1:0]    r_flush_cnt;

    assign w_rs_ext = TAG_RN_W'(i_id_rs);
    assign w_rt_ext = TAG_RN_W'(i_id_rt);

    // The decode tag only claims a write when the instruction is real,
    // so a squashed slot can never become a forwarding source.
    always_comb begin
        w_dec_tag       = TAG_EMPTY;
        w_dec_tag.valid = i_id_valid;
        w_dec_tag.rn    = TAG_RN_W'(i_id_rn);
        w_dec_tag.wreg  = i_id_wreg & i_id_valid;
        w_dec_tag.m2reg = i_id_m2reg & i_id_valid;
    end

    // Only stage 1 ever receives a load-use bubble; deeper stages keep
    // shifting so the producing load drains toward its forwarding point.
    assign w_bubble = {{(STAGES-1){1'b0}}, w_stall};

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign w_tag_d[gi] = w_dec_tag;
            end else begin : g_body
                assign w_tag_d[gi] = w_tag_q[gi-1];
            end

            pipe_tag_reg u_tag (
                .i_clk    (i_clk),
                .i_rst    (i_rst),
                .i_hold   (i_mc_busy),
                .i_bubble (w_bubble[gi]),
                .i_load   (~i_mc_busy),
                .i_tag    (w_tag_d[gi]),
                .o_tag    (w_tag_q[gi])
            );

            // Register 0 is hard-wired and never forwarded.
            assign w_hit_a[gi] = i_id_use_rs && (w_rs_ext != '0)
                              && w_tag_q[gi].valid && w_tag_q[gi].wreg
                              && (w_tag_q[gi].rn == w_rs_ext);
            assign w_hit_b[gi] = i_id_use_rt && (w_rt_ext != '0)
                              && w_tag_q[gi].valid && w_tag_q[gi].wreg
                              && (w_tag_q[gi].rn == w_rt_ext);

            assign o_stage_valid[gi] = w_tag_q[gi].valid;
        end
    endgenerate

    // Youngest producer wins: scan from the top stage down so the
    // lowest-numbered matching stage is the last to overwrite.
    always_comb begin
        w_fwd_a = FWD_W'(FWD_RF);
        w_fwd_b = FWD_W'(FWD_RF);
        w_lu_a  = 1'b0;
        w_lu_b  = 1'b0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            if (w_hit_a[k]) begin
                w_fwd_a = FWD_W'(k + 1);
                w_lu_a  = w_tag_q[k].m2reg && ((k + 1) < LOAD_STAGE);
            end
            if (w_hit_b[k]) begin
                w_fwd_b = FWD_W'(k + 1);
                w_lu_b  = w_tag_q[k].m2reg && ((k + 1) < LOAD_STAGE);
            end
        end
    end

    assign w_load_use = w_lu_a | w_lu_b;

    // Freeze beats load-use, load-use beats the branch flush: a branch
    // decided on stale operands must wait until the stall clears.
    assign w_stall = ~i_mc_busy & w_load_use;
    assign w_flush = ~i_mc_busy & ~w_load_use & i_branch_taken;

    // Reset overrides everything so fetch is released while reset is held.
    assign o_wpcir     = i_rst | ~(i_mc_busy | w_load_use);
    assign o_id_bubble = ~i_rst & w_stall;
    assign o_if_flush  = ~i_rst & w_flush;
    assign o_fwd_a     = w_fwd_a;
    assign o_fwd_b     = w_fwd_b;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_flush && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign o_stall_cnt = r_stall_cnt;
    assign o_flush_cnt = r_flush_cnt;

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter STAGES, default 3: number of result-holding stages after decode (1=EXE, 2=MEM, 3=WB); legal 2..8.
REQ-002 Parameter REG_AW, default 5: register-number width.
REQ-003 Parameter LOAD_STAGE, default 2: stage at whose end load data becomes forwardable; legal 1..STAGES.
REQ-004 Parameter CNT_W, default 16: width of the performance counters.
REQ-005 Clock  in  1  single clock; all state updates on the rising edge.
REQ-006 Reset  in  1  asynchronous, active-high reset.
REQ-007 id_valid  in  1  decode stage holds a real instruction.
REQ-008 id_rs, id_rt  in  REG_AW each  source register numbers.
REQ-009 id_use_rs, id_use_rt  in  1 each  source is actually read.
REQ-010 id_rn  in  REG_AW  destination register.
REQ-011 id_wreg, id_m2reg  in  1 each  writes register / result comes from memory.
REQ-012 branch_taken  in  1  decode resolved a redirect this cycle.
REQ-013 mc_busy  in  1  external multi-cycle unit requests whole-pipe freeze.
REQ-014 wpcir  out  1  PC and IF/ID register write enable (1 = advance).
REQ-015 id_bubble  out  1  ID/EXE register loads a bubble.
REQ-016 if_flush  out  1  IF/ID register loads a bubble.
REQ-017 fwd_a, fwd_b  out  clog2(STAGES+1) each  0 = register file, k = result of stage k.
REQ-018 stage_valid  out  STAGES  valid bit per tracked stage.
REQ-019 stall_cnt, flush_cnt  out  CNT_W each  load-use stall cycles / flushes taken.

Function
REQ-020 Block SHALL hold one tag {valid, rn, wreg, m2reg} per stage 1..STAGES.
REQ-021 Per source, match SHALL be the lowest k with valid, wreg, rn==src, rn!=0 and use bit set; fwd = k, else 0; register 0 never matches.
REQ-022 Match at k with m2reg and k<LOAD_STAGE SHALL raise load_use (combinational); fwd value is then don't-care.
REQ-023 Priority SHALL be: Reset > mc_busy > load_use > branch_taken.
REQ-024 mc_busy=1: wpcir=0, id_bubble=0, if_flush=0, all tags hold, counters hold.
REQ-025 load_use (no mc_busy): wpcir=0, id_bubble=1, if_flush=0; tags shift with a bubble (valid=0) entering stage 1; stall_cnt increments.
REQ-026 branch_taken without stall/freeze: wpcir=1, if_flush=1, id_bubble=0; decode instruction enters stage 1; flush_cnt increments.
REQ-027 Otherwise: wpcir=1, id_bubble=0, if_flush=0; stage1 <= {id_valid, id_rn, id_wreg & id_valid, id_m2reg & id_valid}; stage k <= stage k-1.
REQ-028 Tag of stage STAGES SHALL be dropped after its cycle in the top stage (writeback completes that cycle).
REQ-029 Counters SHALL saturate at all-ones, never wrap.
REQ-030 Load-use latency: a load followed immediately by a dependent instruction SHALL cost exactly LOAD_STAGE-1 stall cycles.
REQ-031 All outputs except stage_valid and counters SHALL be combinational from current tags and inputs.

Reset
REQ-032 Reset SHALL asynchronously clear all tags (stage_valid=0), stall_cnt=0, flush_cnt=0.
REQ-033 During and after reset with idle inputs: wpcir=1, id_bubble=0, if_flush=0, fwd_a=fwd_b=0.
REQ-034 Reset asserted mid-stall SHALL abandon the stall; first post-reset cycle re-evaluates from empty tags.

Structure
REQ-035 Shared package pipe_pkg SHALL hold the stage-tag typedef, default STAGES/REG_AW/LOAD_STAGE/CNT_W and the fwd encoding constant FWD_RF=0.
REQ-036 One sub-module pipe_tag_reg SHALL implement a single stage tag register with hold/load/bubble controls, instantiated STAGES times.

Verification
REQ-037 Reset mid-run -> stage_valid=000, counters 0, wpcir=1 immediately (before next edge).
REQ-038 add r3 into stage1, decode reads r3 as rs -> fwd_a=1; next cycle fwd_a=2; then 3; then 0.
REQ-039 lw r5 in stage1 (LOAD_STAGE=2), decode uses r5 -> one cycle wpcir=0, id_bubble=1, stall_cnt=1; next cycle fwd=2, wpcir=1.
REQ-040 mc_busy=1 for 4 cycles with lw dependency pending -> tags frozen, stall_cnt unchanged, wpcir=0, id_bubble=0 throughout.
REQ-041 branch_taken=1 with load_use same cycle -> if_flush=0, flush_cnt unchanged; branch_taken repeated next cycle -> if_flush=1, flush_cnt=1.
REQ-042 STAGES=5, LOAD_STAGE=3, stall_cnt preset near all-ones via forced stalls -> saturates at 0xFFFF; lw-use costs 2 stall cycles.
